sequence_player: RTL

Plays back the stored Simon sequence: on `start`, reads the first `level` entries from the sequence ROM in address order and lights one of four LEDs per entry for a timed on/off interval. It is the read side of the sequence ROM, complementary to the sequence loader that fills it. It sits between the ROM and the LED driver and is sequenced by the game controller through `start`/`busy`/`done`.

---
 rtl/sequence_player.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/sequence_player.sv
// sequence_player: plays the first `level` ROM entries onto four one-hot LEDs.
// Build option: define SEQ_PLAYER_GAP_EN to add an OFF_TICKS dark gap after each step.
module sequence_player #(
    parameter int N         = 10,
    parameter int ON_TICKS  = 3,
    parameter int OFF_TICKS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic [3:0] level,
    output logic [3:0] rd_addr,
    input  logic [1:0] rd_data,
    output logic [3:0] led,
    output logic       busy,
    output logic       done
);

    localparam int CMAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int CW   = (CMAX < 2) ? 1 : $clog2(CMAX);

    localparam logic [CW-1:0] ON_LAST  = CW'(ON_TICKS - 1);
`ifdef SEQ_PLAYER_GAP_EN
    localparam logic [CW-1:0] OFF_LAST = CW'(OFF_TICKS - 1);
`endif
    localparam logic [4:0] N_CAP = 5'(N);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] LATCH = 3'd2;
    localparam logic [2:0] ON    = 3'd3;
`ifdef SEQ_PLAYER_GAP_EN
    localparam logic [2:0] OFF   = 3'd4;
`endif
    localparam logic [2:0] FIN   = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [4:0]    eff_q, eff_d;
    logic [3:0]    rd_addr_q, rd_addr_d;
    logic [3:0]    led_q, led_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          adv;

    // Next-state logic: playback sequencing, tick counting and step advance.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        eff_d     = eff_q;
        rd_addr_d = rd_addr_q;
        led_d     = led_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cnt_d     = cnt_q;
        adv       = 1'b0;

        unique case (state_q)
            IDLE, FIN: begin
                led_d = '0;
                if (state_q == FIN) begin
                    state_d = IDLE;
                end
                if (start) begin
                    if (level != 4'd0) begin
                        eff_d     = ({1'b0, level} > N_CAP) ? N_CAP : {1'b0, level};
                        idx_d     = '0;
                        rd_addr_d = '0;
                        busy_d    = 1'b1;
                        state_d   = FETCH;
                    end else begin
                        done_d  = 1'b1;
                        state_d = FIN;
                    end
                end
            end
            // rd_addr already holds idx; wait out the ROM read latency.
            FETCH: state_d = LATCH;
            LATCH: begin
                led_d   = 4'b0001 << rd_data;
                cnt_d   = '0;
                state_d = ON;
            end
            ON: begin
                if (tick) begin
                    if (cnt_q == ON_LAST) begin
                        led_d = '0;
                        cnt_d = '0;
`ifdef SEQ_PLAYER_GAP_EN
                        state_d = OFF;
`else
                        adv = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
`ifdef SEQ_PLAYER_GAP_EN
            OFF: begin
                if (tick) begin
                    if (cnt_q == OFF_LAST) begin
                        cnt_d = '0;
                        adv   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        if (adv) begin
            if ({1'b0, idx_q} == eff_q - 5'd1) begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = FIN;
            end else begin
                idx_d     = idx_q + 4'd1;
                rd_addr_d = idx_q + 4'd1;
                state_d   = FETCH;
            end
        end
    end

    // State and output registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            eff_q     <= '0;
            rd_addr_q <= '0;
            led_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            eff_q     <= eff_d;
            rd_addr_q <= rd_addr_d;
            led_q     <= led_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
        end
    end

    assign rd_addr = rd_addr_q;
    assign led     = led_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
